// File: rtl/capture_scheduler.sv
// Frame capture scheduler: grants one frame to the highest-priority pending
// request, pulses the pixel trigger, watches for frame end and enforces hold-off.
module capture_scheduler #(
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 4096,
    parameter int HOLDOFF  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [7:0]          cfg_expose,
    input  logic                sw_trigger,
    input  logic                ext_trigger,
    input  logic                mon_valid,
    input  logic                mon_ready,
    input  logic                mon_tlast,
    input  logic                err_clr,
    output logic                pix_trigger,
    output logic [7:0]          pix_expose,
    output logic                busy,
    output logic [1:0]          last_src,
    output logic [PERIOD_W-1:0] frame_cnt,
    output logic [7:0]          overrun_cnt,
    output logic                err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_HOLD} state_t;

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int HLD_W = $clog2(HOLDOFF + 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    state_t              state, next_state;
    logic                ext_d;
    logic [PERIOD_W-1:0] timer_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [HLD_W-1:0]    hold_cnt;

    logic                ext_req, timer_on, tick, req_any, frame_end, timed_out;
    logic [PERIOD_W-1:0] period_m1;
    logic [1:0]          grant_src;
    logic                grant, done, abort;

    assign ext_req   = ext_trigger & ~ext_d;
    assign timer_on  = cfg_enable && (cfg_period != '0);
    assign period_m1 = cfg_period - PERIOD_W'(1);
    assign tick      = timer_on && (timer_cnt == period_m1);
    assign req_any   = ext_req | sw_trigger | tick;
    assign frame_end = mon_valid & mon_ready & mon_tlast;
    assign timed_out = (tmo_cnt == TMO_LAST);
    assign grant_src = ext_req ? 2'b01 : (sw_trigger ? 2'b10 : 2'b11);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        next_state = state;
        grant      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    grant      = 1'b1;
                    next_state = S_ARM;
                end
            end
            S_ARM: next_state = S_WAIT;
            S_WAIT: begin
                if (frame_end)      done  = 1'b1;
                else if (timed_out) abort = 1'b1;
                if (done || abort)
                    next_state = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HLD_LAST) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Timer keeps running in every state; a shrunken period wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    timer_cnt <= '0;
        else if (!timer_on || timer_cnt >= period_m1) timer_cnt <= '0;
        else                                        timer_cnt <= timer_cnt + PERIOD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_d       <= 1'b0;
            pix_trigger <= 1'b0;
            pix_expose  <= '0;
            last_src    <= '0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
            hold_cnt    <= '0;
        end else begin
            ext_d       <= ext_trigger;
            pix_trigger <= (state == S_ARM);
            if (grant) begin
                pix_expose <= cfg_expose;
                last_src   <= grant_src;
            end
            if (done) frame_cnt <= frame_cnt + PERIOD_W'(1);
            // Losers of a grant cycle are merged; only requests while busy count.
            if (req_any && busy && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            if (abort)        err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
            if (state == S_ARM)       tmo_cnt <= '0;
            else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state == S_HOLD) hold_cnt <= hold_cnt + HLD_W'(1);
            else                 hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_capture_scheduler.sv
// Randomised bench for capture_scheduler: a timestamp-based reference model
// predicts grants into a scoreboard that a negedge monitor drains.
module tb_capture_scheduler;

    localparam int PERIOD_W = 16;
    localparam int TIMEOUT  = 16;
    localparam int HOLDOFF  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_enable = 1'b0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic [7:0]          cfg_expose = '0;
    logic                sw_trigger = 1'b0;
    logic                ext_trigger = 1'b0;
    logic                mon_valid = 1'b0;
    logic                mon_ready = 1'b0;
    logic                mon_tlast = 1'b0;
    logic                err_clr = 1'b0;
    logic                pix_trigger;
    logic [7:0]          pix_expose;
    logic                busy;
    logic [1:0]          last_src;
    logic [PERIOD_W-1:0] frame_cnt;
    logic [7:0]          overrun_cnt;
    logic                err_timeout;

    always #5 clk = ~clk;

    capture_scheduler #(.PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
        .cfg_expose(cfg_expose), .sw_trigger(sw_trigger), .ext_trigger(ext_trigger),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_tlast(mon_tlast),
        .err_clr(err_clr), .pix_trigger(pix_trigger), .pix_expose(pix_expose),
        .busy(busy), .last_src(last_src), .frame_cnt(frame_cnt),
        .overrun_cnt(overrun_cnt), .err_timeout(err_timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle c is the interval after clock edge c. A frame is
    // described by the edge it was granted at and the edge it finished at.
    typedef struct {
        int       cyc;
        bit [1:0] src;
        bit [7:0] expose;
    } grant_t;

    grant_t   sb[$];
    int       n = 0;
    bit       m_active;
    int       m_grant, m_end, m_tcount, m_frames, m_over;
    bit       m_ext_prev, m_err;
    bit [1:0] m_src;
    bit [7:0] m_expose;

    function automatic bit m_idle(input int c);
        return !m_active || (m_end >= 0 && c >= m_end + HOLDOFF);
    endfunction

    task automatic model_reset();
        m_active = 0; m_grant = 0; m_end = -1; m_tcount = 0; m_frames = 0;
        m_over = 0; m_ext_prev = 0; m_err = 0; m_src = 0; m_expose = 0;
        sb.delete();
    endtask

    task automatic model_edge();
        int c;
        bit tick, ext_req, req, idle, waiting, aborted;
        grant_t g;
        c       = n;
        tick    = cfg_enable && cfg_period != 0 && m_tcount == int'(cfg_period) - 1;
        ext_req = ext_trigger && !m_ext_prev;
        req     = ext_req || sw_trigger || tick;
        idle    = m_idle(c);
        waiting = m_active && m_end < 0 && c > m_grant;
        aborted = 0;
        if (!cfg_enable || cfg_period == 0 || m_tcount >= int'(cfg_period) - 1) m_tcount = 0;
        else m_tcount++;
        m_ext_prev = ext_trigger;
        if (waiting) begin
            if (mon_valid && mon_ready && mon_tlast) begin
                m_end = c + 1;
                m_frames = (m_frames + 1) % (1 << PERIOD_W);
            end else if (c - m_grant == TIMEOUT) begin
                m_end = c + 1;
                aborted = 1;
            end
        end
        if (aborted)      m_err = 1;
        else if (err_clr) m_err = 0;
        if (idle && req) begin
            m_active = 1;
            m_grant  = c + 1;
            m_end    = -1;
            m_src    = ext_req ? 2'b01 : (sw_trigger ? 2'b10 : 2'b11);
            m_expose = cfg_expose;
            g.cyc = c + 2; g.src = m_src; g.expose = m_expose;
            sb.push_back(g);
        end else if (!idle && req && m_over < 255) begin
            m_over++;
        end
        n = c + 1;
    endtask

    bit mon_on = 0;
    bit rand_mon = 0;
    bit clr_on_abort = 0;
    int tlast_delay = 12;

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            bit     exp_trig;
            grant_t g;
            exp_trig = (sb.size() > 0) && (sb[0].cyc == n);
            chk("pix_trigger", {31'b0, pix_trigger}, {31'b0, exp_trig});
            if (sb.size() > 0 && sb[0].cyc <= n) begin
                g = sb.pop_front();
                if (exp_trig && pix_trigger) begin
                    chk("grant_src", {30'b0, last_src}, {30'b0, g.src});
                    chk("grant_expose", {24'b0, pix_expose}, {24'b0, g.expose});
                end
            end
            chk("busy", {31'b0, busy}, {31'b0, !m_idle(n)});
            chk("frame_cnt", {16'b0, frame_cnt}, m_frames);
            chk("overrun_cnt", {24'b0, overrun_cnt}, m_over);
            chk("err_timeout", {31'b0, err_timeout}, {31'b0, m_err});
            chk("last_src", {30'b0, last_src}, {30'b0, m_src});
            chk("pix_expose", {24'b0, pix_expose}, {24'b0, m_expose});
        end
    end

    task automatic step(input bit sw, input bit clr);
        bit hs;
        sw_trigger = sw;
        err_clr = clr | (clr_on_abort && m_active && m_end < 0 && n - m_grant == TIMEOUT);
        if (rand_mon) begin
            mon_valid = $urandom_range(0, 1) == 1;
            mon_ready = $urandom_range(0, 1) == 1;
            mon_tlast = $urandom_range(0, 9) == 0;
        end else begin
            hs = m_active && m_end < 0 && (n - m_grant == tlast_delay);
            mon_valid = hs; mon_ready = hs; mon_tlast = hs;
        end
        @(posedge clk);
        if (rst) n++;
        else     model_edge();
        #1;
        sw_trigger = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_trigger"}, {31'b0, pix_trigger}, 0);
        chk({tag, "_pix_expose"}, {24'b0, pix_expose}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_last_src"}, {30'b0, last_src}, 0);
        chk({tag, "_frame_cnt"}, {16'b0, frame_cnt}, 0);
        chk({tag, "_overrun_cnt"}, {24'b0, overrun_cnt}, 0);
        chk({tag, "_err_timeout"}, {31'b0, err_timeout}, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) step(0, 0);
        check_all_zero("reset");
        rst = 1'b0;
        mon_on = 1;

        // Single software shot with a clean frame end.
        repeat (8) step(0, 0);
        step(1, 0);
        repeat (30) step(0, 0);

        // External level held high: one grant; sw while waiting is an overrun.
        ext_trigger = 1'b1;
        for (int i = 0; i < 20; i++) step(i == 8, 0);
        ext_trigger = 1'b0;
        repeat (10) step(0, 0);

        // Periodic capture.
        tlast_delay = 10;
        cfg_period = 16'd100;
        cfg_enable = 1'b1;
        repeat (1000) step(0, 0);
        cfg_enable = 1'b0;
        repeat (20) step(0, 0);

        // Ext edge, sw and tick together in one idle cycle.
        tlast_delay = 2;
        cfg_period = 16'd5;
        cfg_enable = 1'b1;
        for (int i = 0; i < 60 && !(m_idle(n) && m_tcount == 4); i++) step(0, 0);
        ext_trigger = 1'b1;
        cfg_expose = 8'hA5;
        step(1, 0);
        cfg_enable = 1'b0;
        cfg_expose = 8'h3C;
        repeat (15) step(0, 0);
        ext_trigger = 1'b0;
        repeat (5) step(0, 0);

        // Timeout, then clear colliding with a second timeout, then a lone clear.
        tlast_delay = 1000;
        step(1, 0);
        repeat (25) step(0, 0);
        clr_on_abort = 1;
        step(1, 0);
        repeat (25) step(0, 0);
        clr_on_abort = 0;
        step(0, 1);
        repeat (3) step(0, 0);

        // Saturate the overrun counter.
        repeat (400) step(1, 0);
        repeat (25) step(0, 0);

        // Reset while pix_trigger is high, then a normal grant.
        tlast_delay = 6;
        step(1, 0);
        step(0, 0);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        model_reset();
        repeat (2) step(0, 0);
        rst = 1'b0;
        step(1, 0);
        repeat (20) step(0, 0);

        // Randomised traffic.
        rand_mon = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                cfg_enable = $urandom_range(0, 1) == 1;
                cfg_period = 16'($urandom_range(0, 40));
            end
            cfg_expose = 8'($urandom);
            if ($urandom_range(0, 5) == 0) ext_trigger = ~ext_trigger;
            step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end

        mon_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
